// File: rtl/gactx_drv_pkg.sv
// Shared types and constants for the GACT-X tile driver: FSM encoding, bus widths
// and the base-count to seq-word conversion.
package gactx_drv_pkg;

    localparam int DIR_W = 128;
    localparam int RES_W = 512;
    localparam int SEQ_W = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_REF  = 3'd1,
        LOAD_QRY  = 3'd2,
        ARM       = 3'd3,
        WAIT_DONE = 3'd4,
        RESULT    = 3'd5,
        DRAIN     = 3'd6
    } state_t;

    // ceil(len / bpw); the 33-bit sum keeps a near-max length from wrapping
    function automatic logic [31:0] word_count(input logic [31:0] len, input int bpw);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'(bpw - 1);
        return 32'(sum / 33'(bpw));
    endfunction

endpackage

// File: rtl/gactx_tile_driver_dir_fifo.sv
// First-word-fall-through sync FIFO used to buffer traceback beats; head is valid
// whenever empty is low.
module gactx_dir_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gactx_tile_driver.sv
// Host-side initiator for the GACT-X array wrapper: loads ref/query words, starts a
// tile, returns the result and streams traceback beats. Option: GACTX_DRV_PERF_EN.
module gactx_tile_driver
    import gactx_drv_pkg::*;
#(
    parameter int NUM_DIR_BLOCK  = DIR_W / 2,
    parameter int LOG_MAX_TILE   = 13,
    parameter int BASES_PER_WORD = 8,
    parameter int ADDR_BASE      = 1,
    parameter int DIR_FIFO_DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [31:0]                desc_ref_len,
    input  logic [31:0]                desc_qry_len,
    input  logic [31:0]                desc_ref_off,
    input  logic [31:0]                desc_qry_off,
    input  logic [SEQ_W-1:0]           seq_data,
    input  logic                       seq_valid,
    output logic                       seq_ready,
    output logic [SEQ_W-1:0]           ref_in,
    output logic [SEQ_W-1:0]           query_in,
    output logic [31:0]                ref_addr,
    output logic [31:0]                query_addr,
    output logic [31:0]                ref_len,
    output logic [31:0]                query_len,
    output logic [31:0]                ref_off,
    output logic [31:0]                query_off,
    output logic                       ref_wr_en,
    output logic                       query_wr_en,
    output logic                       start,
    output logic                       clear_done,
    input  logic                       arr_ready,
    input  logic                       done_GACT,
    input  logic [RES_W-1:0]           tile_output,
    input  logic [31:0]                dir_out_count,
    input  logic [2*NUM_DIR_BLOCK-1:0] dir_out,
    input  logic                       dir_out_valid,
    output logic [RES_W-1:0]           res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*NUM_DIR_BLOCK-1:0] dir_data,
    output logic                       dir_valid,
    input  logic                       dir_ready,
    output logic                       dir_last,
    output logic                       dir_overflow
`ifdef GACTX_DRV_PERF_EN
    ,
    output logic [31:0]                perf_cycles
`endif
);

    localparam int DW   = 2 * NUM_DIR_BLOCK;
    localparam int WC_W = LOG_MAX_TILE + 1;

    state_t          state, state_nxt;
    logic [WC_W-1:0] nwr, nwq, wcnt, nw_cur, nwr_in, nwq_in;
    logic [31:0]     dcnt, rcv, eff_cnt;
    logic            accept_seq, last_word, wr_busy, fire;
    logic            cap_state, dir_push, dir_pop, beat_last;
    logic            fifo_full, fifo_empty;
    logic [DW:0]     fifo_dout;

    assign nwr_in     = WC_W'(word_count(desc_ref_len, BASES_PER_WORD));
    assign nwq_in     = WC_W'(word_count(desc_qry_len, BASES_PER_WORD));
    assign nw_cur     = (state == LOAD_QRY) ? nwq : nwr;
    assign accept_seq = seq_valid && seq_ready;
    assign last_word  = ((wcnt + WC_W'(1)) == nw_cur);
    assign wr_busy    = ref_wr_en || query_wr_en;
    assign fire       = (state == ARM) && arr_ready && !wr_busy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (desc_valid)
                           state_nxt = (nwr_in != '0) ? LOAD_REF :
                                       (nwq_in != '0) ? LOAD_QRY : ARM;
            LOAD_REF:  if (accept_seq && last_word)
                           state_nxt = (nwq != '0) ? LOAD_QRY : ARM;
            LOAD_QRY:  if (accept_seq && last_word) state_nxt = ARM;
            ARM:       if (fire) state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_GACT) state_nxt = RESULT;
            RESULT:    if (res_ready) state_nxt = (dcnt != '0) ? DRAIN : IDLE;
            DRAIN:     if ((rcv == dcnt) && fifo_empty) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        desc_ready = 1'b0;
        seq_ready  = 1'b0;
        res_valid  = 1'b0;
        unique case (state)
            IDLE:               desc_ready = 1'b1;
            LOAD_REF, LOAD_QRY: seq_ready  = 1'b1;
            RESULT:             res_valid  = 1'b1;
            default:            ;
        endcase
    end

    // dir_out_count is only latched on done, so a beat arriving with done uses the live count
    assign cap_state = (state == WAIT_DONE) || (state == RESULT) || (state == DRAIN);
    assign dir_push  = cap_state && dir_out_valid;
    assign eff_cnt   = (state == WAIT_DONE) ? dir_out_count : dcnt;
    assign beat_last = (rcv == eff_cnt - 32'd1);
    assign dir_pop   = dir_valid && dir_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_len      <= '0;
            query_len    <= '0;
            ref_off      <= '0;
            query_off    <= '0;
            nwr          <= '0;
            nwq          <= '0;
            wcnt         <= '0;
            ref_in       <= '0;
            query_in     <= '0;
            ref_addr     <= '0;
            query_addr   <= '0;
            ref_wr_en    <= 1'b0;
            query_wr_en  <= 1'b0;
            start        <= 1'b0;
            clear_done   <= 1'b0;
            res_data     <= '0;
            dcnt         <= '0;
            rcv          <= '0;
            dir_overflow <= 1'b0;
        end else begin
            ref_wr_en   <= 1'b0;
            query_wr_en <= 1'b0;
            start       <= 1'b0;
            clear_done  <= 1'b0;
            if ((state == IDLE) && desc_valid) begin
                ref_len   <= desc_ref_len;
                query_len <= desc_qry_len;
                ref_off   <= desc_ref_off;
                query_off <= desc_qry_off;
                nwr       <= nwr_in;
                nwq       <= nwq_in;
                wcnt      <= '0;
            end
            if (accept_seq) begin
                if (state == LOAD_REF) begin
                    ref_wr_en <= 1'b1;
                    ref_in    <= seq_data;
                    ref_addr  <= 32'(ADDR_BASE) + 32'(wcnt);
                end else begin
                    query_wr_en <= 1'b1;
                    query_in    <= seq_data;
                    query_addr  <= 32'(ADDR_BASE) + 32'(wcnt);
                end
                wcnt <= last_word ? '0 : wcnt + WC_W'(1);
            end
            if (fire) begin
                start <= 1'b1;
                rcv   <= '0;
            end
            if ((state == WAIT_DONE) && done_GACT) begin
                res_data   <= tile_output;
                dcnt       <= dir_out_count;
                clear_done <= 1'b1;
            end
            // beats cannot be stalled: a dropped beat still counts toward the tile total
            if (dir_push) begin
                rcv <= rcv + 32'd1;
                if (fifo_full && !dir_pop) dir_overflow <= 1'b1;
            end
        end
    end

    gactx_dir_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (DIR_FIFO_DEPTH)
    ) u_dir_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dir_push),
        .din   ({beat_last, dir_out}),
        .pop   (dir_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dir_valid = !fifo_empty;
    assign dir_data  = fifo_empty ? '0 : fifo_dout[DW-1:0];
    assign dir_last  = !fifo_empty && fifo_dout[DW];

`ifdef GACTX_DRV_PERF_EN
    logic [31:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt        <= '0;
            perf_cycles <= '0;
        end else if (fire) begin
            pcnt <= '0;
        end else if (state == WAIT_DONE) begin
            if (done_GACT)          perf_cycles <= pcnt;
            else if (pcnt != '1)    pcnt        <= pcnt + 32'd1;
        end
    end
`endif

endmodule
